fifo_stream_reader: RTL and testbench

- Read-side adapter for the team's synchronous FIFO. Drives the FIFO's pop and absorbs its one-cycle registered read latency.
- Presents FIFO contents as a valid/ready stream to downstream logic. Full throughput (one word per cycle) is sustained under continuous ready.
- Holds a 2-entry output skid buffer and an optional synchronous flush. Sits between any FIFO instance and a stream consumer.

---
 rtl/stream_skid2.sv | 57 +++++
 rtl/fifo_stream_reader.sv | 55 +++++
 tb/tb_fifo_stream_reader.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_skid2.sv
// Two-entry valid/ready skid register: head drives the output, tail absorbs
// one extra word so the upstream credit loop never has to stall mid-word.
module stream_skid2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occ,
  output logic             accept
);

  localparam logic [1:0] DEPTH = 2'd2;

  logic [WIDTH-1:0] head, tail;
  logic [WIDTH-1:0] head_d, tail_d;
  logic [1:0]       occ_q, occ_d, occ_after;

  assign out_valid = (occ_q != 2'd0);
  assign out_data  = head;
  assign occ       = occ_q;
  assign accept    = out_valid && out_ready;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    head_d    = head;
    tail_d    = tail;
    occ_after = occ_q - {1'b0, accept};
    if (accept && occ_q == DEPTH) head_d = tail;
    // A captured word lands in the first slot left free after the accept.
    if (in_valid) begin
      if (occ_after == 2'd0) head_d = in_data;
      else                   tail_d = in_data;
    end
    occ_d = occ_after + {1'b0, in_valid};
    if (clear) occ_d = 2'd0;
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  // NOTE: tail is don't-care whenever occ < 2, so only control and the visible head are reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      occ_q <= 2'd0;
    end else begin
      head  <= head_d;
      occ_q <= occ_d;
    end
    tail <= tail_d;
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side adapter for the synchronous FIFO: pops with a credit check that
// covers the one-cycle read latency and presents the words as a stream.
module fifo_stream_reader #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  input  logic [WIDTH-1:0]     fifo_q,
  output logic                 fifo_pop,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [CNT_WIDTH-1:0] delivered,
  output logic                 busy
);

  logic       inflight;
  logic       accept;
  logic [1:0] occ;
  logic [2:0] credit;

  // Slots already committed: held words plus the word still coming out of the FIFO.
  assign credit   = {1'b0, occ} + {2'b00, inflight};
  assign fifo_pop = !rst && !flush && !fifo_empty &&
                    (credit < (3'd2 + {2'b00, accept}));
  assign busy     = (occ != 2'd0) || inflight;

  stream_skid2 #(.WIDTH(WIDTH)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .in_valid  (inflight),
    .in_data   (fifo_q),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .occ       (occ),
    .accept    (accept)
  );

  // fifo_pop is already low under flush, so inflight clears without a special case.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight  <= 1'b0;
      delivered <= '0;
    end else begin
      inflight <= fifo_pop;
      if (accept) delivered <= delivered + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench: a queue-based FIFO feeds the reader; a scoreboard of
// popped words predicts every output each cycle, plus directed literal checks.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty;
  logic [7:0]  fifo_q;
  logic        fifo_pop;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic [31:0] delivered;
  logic        busy;

  fifo_stream_reader #(.WIDTH(8), .CNT_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_q     (fifo_q),
    .fifo_pop   (fifo_pop),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .delivered  (delivered),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous FIFO environment: registered read data, combinational empty.
  logic [7:0] fq[$];
  logic [7:0] load_buf[$];
  logic       load_en = 1'b0;
  logic       push_en = 1'b0;
  logic [7:0] push_data = 8'h00;
  int         fcount = 0;

  assign fifo_empty = (fcount == 0);

  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
      fifo_q <= 8'h00;
    end else if (fifo_pop && fq.size() > 0) begin
      fifo_q <= fq.pop_front();
    end
    if (load_en) foreach (load_buf[i]) fq.push_back(load_buf[i]);
    if (push_en) fq.push_back(push_data);
    fcount = fq.size();
  end

  // Reference model: ordered list of words taken from the FIFO but not yet
  // delivered; a word becomes presentable one edge after it was popped.
  typedef struct packed {
    logic [7:0] d;
    logic       cap;
  } ent_t;

  ent_t        sb[$];
  logic [31:0] dcount = 0;
  logic [7:0]  got[$];
  int          acc_cyc[$];
  int          pop_cyc[$];
  bit          model_on = 0;

  always @(negedge clk) begin
    if (model_on) begin
      bit exp_valid, acc, exp_pop;
      int pending;
      exp_valid = (sb.size() > 0) && sb[0].cap;
      check("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
      if (exp_valid) check("out_data", {24'b0, out_data}, {24'b0, sb[0].d});
      check("delivered", delivered, dcount);
      check("busy", {31'b0, busy}, {31'b0, sb.size() != 0});
      acc     = exp_valid && out_ready;
      pending = sb.size() - (acc ? 1 : 0);
      exp_pop = !rst && !flush && !fifo_empty && (pending < 2);
      check("fifo_pop", {31'b0, fifo_pop}, {31'b0, exp_pop});
      check("pop_on_empty", {31'b0, fifo_pop & fifo_empty}, 32'd0);
      if (fifo_pop) pop_cyc.push_back(cyc);
      if (rst) begin
        sb.delete();
        dcount = 0;
      end else begin
        foreach (sb[i]) sb[i].cap = 1'b1;
        if (acc) begin
          got.push_back(sb[0].d);
          acc_cyc.push_back(cyc);
          void'(sb.pop_front());
          dcount = dcount + 1;
        end
        if (flush) sb.delete();
        else if (exp_pop) sb.push_back('{d: fq[0], cap: 1'b0});
      end
    end
    if (rst) model_on = 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_words(input logic [7:0] base, input int n);
    load_buf.delete();
    for (int i = 0; i < n; i++) load_buf.push_back(base + 8'(i));
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
  endtask

  task automatic wait_got(input int target, input int budget);
    int n = 0;
    while (got.size() < target && n < budget) begin
      tick();
      n++;
    end
    if (got.size() < target) check("wait_got_timeout", got.size(), target);
  endtask

  task automatic wait_idle();
    int n = 0;
    out_ready = 1'b1;
    while ((busy || !fifo_empty) && n < 1000) begin
      tick();
      n++;
    end
    check("idle_timeout", {31'b0, busy | ~fifo_empty}, 32'd0);
  endtask

  initial begin
    int b, pb, rel;
    logic [31:0] d0;

    // Reset with the FIFO preloaded by the final reset edge.
    repeat (2) tick();
    load_buf.delete();
    load_buf.push_back(8'h11);
    load_buf.push_back(8'h22);
    load_buf.push_back(8'h33);
    b  = got.size();
    pb = pop_cyc.size();
    load_en = 1'b1;
    tick();
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_delivered", delivered, 32'd0);
    check("reset_out_data", {24'b0, out_data}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    load_en   = 1'b0;
    rst       = 1'b0;
    out_ready = 1'b1;
    rel       = cyc;
    repeat (8) tick();
    check("first_pop_cycle", pop_cyc[pb], rel);
    check("valid_latency", acc_cyc[b] - pop_cyc[pb], 32'd2);
    check("w0", {24'b0, got[b]},   32'h11);
    check("w1", {24'b0, got[b+1]}, 32'h22);
    check("w2", {24'b0, got[b+2]}, 32'h33);
    check("consecutive", acc_cyc[b+2] - acc_cyc[b], 32'd2);
    check("delivered_3", delivered, 32'd3);
    check("busy_after", {31'b0, busy}, 32'd0);

    // Continuous push of 0..63 under continuous ready.
    b = got.size();
    for (int i = 0; i < 64; i++) begin
      push_en   = 1'b1;
      push_data = 8'(i);
      tick();
    end
    push_en = 1'b0;
    wait_got(b + 64, 200);
    for (int i = 0; i < 64; i++) check("stream_order", {24'b0, got[b+i]}, i);
    check("no_bubble", acc_cyc[b+63] - acc_cyc[b], 32'd63);
    wait_idle();

    // Back-pressure: only two words may be taken while out_ready is low.
    out_ready = 1'b0;
    pb = pop_cyc.size();
    b  = got.size();
    load_words(8'hA0, 8);
    repeat (10) tick();
    check("bp_pops", pop_cyc.size() - pb, 32'd2);
    check("bp_valid", {31'b0, out_valid}, 32'd1);
    check("bp_data", {24'b0, out_data}, 32'hA0);
    check("bp_pop_low", {31'b0, fifo_pop}, 32'd0);
    out_ready = 1'b1;
    wait_got(b + 8, 100);
    for (int i = 0; i < 8; i++) check("bp_order", {24'b0, got[b+i]}, 32'hA0 + i);
    wait_idle();

    // Ready toggling every cycle.
    b = got.size();
    load_words(8'h40, 20);
    for (int n = 0; n < 200 && got.size() < b + 20; n++) begin
      out_ready = ~out_ready;
      tick();
    end
    check("toggle_count", got.size(), b + 20);
    for (int i = 0; i < 20 && b + i < got.size(); i++)
      check("toggle_order", {24'b0, got[b+i]}, 32'h40 + i);
    wait_idle();

    // Flush with both skid slots full: the two held words are dropped.
    out_ready = 1'b0;
    load_words(8'hC0, 8);
    repeat (6) tick();
    d0 = delivered;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_delivered", delivered, d0);
    check("flush_valid", {31'b0, out_valid}, 32'd0);
    check("flush_busy", {31'b0, busy}, 32'd0);
    b = got.size();
    out_ready = 1'b1;
    wait_got(b + 6, 100);
    for (int i = 0; i < 6; i++) check("flush_next", {24'b0, got[b+i]}, 32'hC2 + i);
    wait_idle();

    // Reset mid-stream in steady state.
    load_words(8'h70, 10);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_delivered", delivered, 32'd0);
    check("rst_pop", {31'b0, fifo_pop}, 32'd0);
    rst = 1'b0;
    tick();

    // Randomised traffic with occasional flush pulses.
    for (int n = 0; n < 3000; n++) begin
      push_en   = ($urandom_range(0, 2) != 0);
      push_data = 8'($urandom);
      out_ready = (n % 600 < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      tick();
    end
    push_en = 1'b0;
    flush   = 1'b0;
    wait_idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
